// File: rtl/cmd_decoder_mc_pkg.sv
// Shared definitions for the command decoder: opcode encodings, FSM state
// encoding and the command / task / memory packet types of the default
// configuration (16-bit command packets).
package cmd_decoder_mc_pkg;

    localparam int CMD_PKT_W  = 16;
    localparam int TASK_PKT_W = CMD_PKT_W - 2;

    typedef enum logic [1:0] {
        OP_TASK   = 2'b00,   // forward a task, or send it to memory when masked off
        OP_REPLAY = 2'b01,   // drain the pipeline and start the next replay iteration
        OP_FV     = 2'b10,   // load the feature-vector count
        OP_WB     = 2'b11    // load the weights boundary and wait for the stream
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GRANT,
        S_WAIT_DRAIN,
        S_WAIT_STREAM,
        S_WAIT_DONE
    } state_e;

    typedef logic [CMD_PKT_W-1:0]  cmd_pkt_t;
    typedef logic [TASK_PKT_W-1:0] task_pkt_t;
    typedef logic [CMD_PKT_W-1:0]  mem_pkt_t;

endpackage

// File: rtl/cmd_decoder_mc_if.sv
// Handshake bundle of the command decoder.
//   in_valid/in_pkt/in_ready        : command input (consumed on valid && ready)
//   task_valid/task_pkt/task_ready  : one-hot RS task dispatch
//   mem_req/mem_grant/mem_valid/mem_pkt : memory request port
// master = the side that issues commands and grants, slave = the decoder.
interface cmd_decoder_mc_if #(
    parameter int PKT_W = 16,
    parameter int N_CH  = 2
);
    logic               in_valid;
    logic [PKT_W-1:0]   in_pkt;
    logic               in_ready;
    logic [N_CH-1:0]    task_valid;
    logic [PKT_W-3:0]   task_pkt;
    logic [N_CH-1:0]    task_ready;
    logic               mem_req;
    logic               mem_grant;
    logic               mem_valid;
    logic [PKT_W-1:0]   mem_pkt;

    modport master (
        output in_valid, in_pkt, task_ready, mem_grant,
        input  in_ready, task_valid, task_pkt, mem_req, mem_valid, mem_pkt
    );

    modport slave (
        input  in_valid, in_pkt, task_ready, mem_grant,
        output in_ready, task_valid, task_pkt, mem_req, mem_valid, mem_pkt
    );
endinterface

// File: rtl/cmd_decoder_mc_task_slot.sv
// Single-entry task holding register with one-hot channel select.
//   load/load_pkt/load_sel : capture a task and its destination channel
//   task_ready             : per-channel ready from the reservation stations
//   task_valid/task_pkt    : held task, valid only on its selected channel
//   full                   : an entry is held
//   fire                   : the held task is taken this cycle
module task_slot
    import cmd_decoder_mc_pkg::*;
#(
    parameter int PKT_W = CMD_PKT_W,
    parameter int N_CH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [PKT_W-3:0]  load_pkt,
    input  logic [N_CH-1:0]   load_sel,
    input  logic [N_CH-1:0]   task_ready,
    output logic [N_CH-1:0]   task_valid,
    output logic [PKT_W-3:0]  task_pkt,
    output logic              full,
    output logic              fire
);

    logic [N_CH-1:0]  sel_q;
    logic [PKT_W-3:0] pkt_q;

    // Gating with reset keeps a pending task from being seen during the
    // reset cycle itself.
    assign task_valid = sel_q & {N_CH{~reset}};
    assign task_pkt   = pkt_q;
    assign full       = |sel_q;
    assign fire       = |(task_valid & task_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
            pkt_q <= '0;
        end else if (load) begin
            // A load in the same cycle as a fire replaces the departing entry.
            sel_q <= load_sel;
            pkt_q <= load_pkt;
        end else if (fire) begin
            sel_q <= '0;
        end
    end

endmodule

// File: rtl/cmd_decoder_mc.sv
// Command decoder / replay controller.
// Decodes 2-bit opcodes from incoming command packets: forwards tasks to the
// RS channels, diverts masked-off tasks to memory, sequences replay
// iterations (drain -> memory request -> stream), and loads configuration.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus                 : command / task / memory handshakes (slave side)
//   rs_empty, pe_idle, bank_busy : drain status
//   stream_end, vertex_done      : stream and vertex completion events
//   cfg_last_iter       : index of the final replay iteration
//   replay_iter, replay_flag, num_fv, weights_boundary,
//   stream_begin, ctl_done, task_complete : status / configuration outputs
module cmd_decoder_mc
    import cmd_decoder_mc_pkg::*;
#(
    parameter int PKT_W    = CMD_PKT_W,
    parameter int N_CH     = 2,
    parameter int N_PE     = 4,
    parameter int MAX_ITER = 4,
    parameter int FV_W     = 5,
    parameter int WB_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    cmd_decoder_mc_if.slave             bus,
    input  logic [N_CH-1:0]             rs_empty,
    input  logic [N_PE-1:0]             pe_idle,
    input  logic                        bank_busy,
    input  logic                        stream_end,
    input  logic                        vertex_done,
    input  logic [$clog2(MAX_ITER)-1:0] cfg_last_iter,
    output logic [$clog2(MAX_ITER)-1:0] replay_iter,
    output logic                        replay_flag,
    output logic [FV_W-1:0]             num_fv,
    output logic [WB_W-1:0]             weights_boundary,
    output logic                        stream_begin,
    output logic                        ctl_done,
    output logic                        task_complete
);

    localparam int IT_W = $clog2(MAX_ITER);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e            state;
    logic [PKT_W-1:0]  pkt_lat;
    logic              mem_req_q;
    logic              grant_to_stream;   // replay request: after grant go to WAIT_STREAM

    opcode_e           op;
    logic [MAX_ITER-1:0] iter_mask;
    logic [CH_W-1:0]   ch_raw;
    logic [N_CH-1:0]   ch_onehot;
    logic [IT_W-1:0]   last_iter;
    logic              accept;
    logic              task_load;
    logic              task_full;
    logic              task_fire;
    logic              drained;

    assign op        = opcode_e'(bus.in_pkt[PKT_W-1 -: 2]);
    assign iter_mask = bus.in_pkt[PKT_W-3 -: MAX_ITER];
    assign ch_raw    = bus.in_pkt[CH_W-1:0];

    // Channel numbers beyond the last RS fold onto channel 0.
    always_comb begin
        ch_onehot = '0;
        if (int'(ch_raw) < N_CH) ch_onehot[ch_raw] = 1'b1;
        else                     ch_onehot[0]      = 1'b1;
    end

    // Out-of-range last-iteration settings clamp to the highest supported one.
    always_comb begin
        if (int'(cfg_last_iter) >= MAX_ITER) last_iter = IT_W'(MAX_ITER - 1);
        else                                 last_iter = cfg_last_iter;
    end

    // A task leaving the slot frees room for a new one in the same cycle.
    assign bus.in_ready = (state == S_IDLE) && (!task_full || task_fire) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign task_load    = accept && (op == OP_TASK) && iter_mask[replay_iter];
    assign drained      = !bank_busy && (&rs_empty) && (&pe_idle) && !task_full;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_valid = mem_req_q && bus.mem_grant && !reset;
    assign bus.mem_pkt   = bus.mem_valid ? pkt_lat : '0;

    task_slot #(
        .PKT_W (PKT_W),
        .N_CH  (N_CH)
    ) u_task_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (task_load),
        .load_pkt   (bus.in_pkt[PKT_W-3:0]),
        .load_sel   (ch_onehot),
        .task_ready (bus.task_ready),
        .task_valid (bus.task_valid),
        .task_pkt   (bus.task_pkt),
        .full       (task_full),
        .fire       (task_fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            pkt_lat          <= '0;
            mem_req_q        <= 1'b0;
            grant_to_stream  <= 1'b0;
            replay_iter      <= '0;
            replay_flag      <= 1'b0;
            num_fv           <= '0;
            weights_boundary <= '0;
            stream_begin     <= 1'b0;
            ctl_done         <= 1'b0;
            task_complete    <= 1'b0;
        end else begin
            stream_begin  <= 1'b0;
            ctl_done      <= 1'b0;
            task_complete <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_TASK: begin
                                // Tasks not enabled for this iteration go to memory.
                                if (!iter_mask[replay_iter]) begin
                                    pkt_lat         <= bus.in_pkt;
                                    mem_req_q       <= 1'b1;
                                    grant_to_stream <= 1'b0;
                                    state           <= S_WAIT_GRANT;
                                end
                            end
                            OP_REPLAY: begin
                                pkt_lat     <= bus.in_pkt;
                                replay_flag <= 1'b1;
                                state       <= S_WAIT_DRAIN;
                            end
                            OP_FV: begin
                                num_fv       <= bus.in_pkt[FV_W-1:0];
                                stream_begin <= 1'b1;
                            end
                            OP_WB: begin
                                weights_boundary <= bus.in_pkt[WB_W-1:0];
                                state            <= S_WAIT_STREAM;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT_GRANT: begin
                    if (bus.mem_grant) begin
                        mem_req_q <= 1'b0;
                        state     <= grant_to_stream ? S_WAIT_STREAM : S_IDLE;
                    end
                end
                S_WAIT_DRAIN: begin
                    if (drained) begin
                        replay_flag <= 1'b0;
                        if (replay_iter >= last_iter) begin
                            ctl_done <= 1'b1;
                            state    <= S_WAIT_DONE;
                        end else begin
                            replay_iter     <= replay_iter + 1'b1;
                            mem_req_q       <= 1'b1;
                            grant_to_stream <= 1'b1;
                            state           <= S_WAIT_GRANT;
                        end
                    end
                end
                S_WAIT_STREAM: begin
                    if (stream_end) state <= S_IDLE;
                end
                S_WAIT_DONE: begin
                    if (vertex_done) begin
                        task_complete <= 1'b1;
                        replay_iter   <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
